axis_frame_regen: RTL

Downstream stage of the 3x3 denoise core. It takes the core's master AXI4-Stream output and re-establishes frame geometry before the video-out path. It locks onto start-of-frame (tuser), counts pixels against H_RES x V_RES, and regenerates clean tuser/tlast markers. It drops pre-lock garbage, flags geometry errors, and decouples backpressure through a registered 2-entry skid buffer.

---
 rtl/axis_frame_regen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/axis_frame_regen.sv
// Frame-geometry regenerator: locks on tuser, counts H_RES x V_RES, rebuilds tuser/tlast, 2-entry skid buffer.
// Optional statistics counters (frame_cnt, drop_cnt) are built when FRAME_REGEN_STATS_EN is defined.
module axis_frame_regen #(
  parameter int DATA_WIDTH = 32,
  parameter int H_RES      = 1920,
  parameter int V_RES      = 1080
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  locked,
  output logic                  err_sof,
  output logic                  err_eol,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam logic [10:0] X_LAST = 11'(H_RES - 1);
  localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

  typedef enum logic {WAIT_SOF, ACTIVE} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  user;
    logic                  last;
  } beat_t;

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] px, py;
  logic        err_sof_q, err_sof_d, err_eol_q, err_eol_d;
  logic        acc, push, pop;
  beat_t       in_beat;
  beat_t       head_q, head_d, tail_q, tail_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        tready_q;

  assign acc = s_axis_tvalid && tready_q;
  assign pop = (cnt_q != 2'd0) && m_axis_tready;

  // Frame tracking: a tuser beat always restarts the position at (0,0).
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    err_sof_d = err_sof_q;
    err_eol_d = err_eol_q;
    push      = 1'b0;
    px        = s_axis_tuser ? 11'd0 : x_q;
    py        = s_axis_tuser ? 11'd0 : y_q;
    in_beat   = '{data: s_axis_tdata, user: (px == 11'd0) && (py == 11'd0), last: (px == X_LAST)};

    if (acc && (state_q == ACTIVE || s_axis_tuser)) begin
      push    = 1'b1;
      state_d = ACTIVE;
      if (state_q == ACTIVE) begin
        if (s_axis_tuser && (x_q != 11'd0 || y_q != 11'd0)) err_sof_d = 1'b1;
        if (s_axis_tlast != in_beat.last)                   err_eol_d = 1'b1;
      end
      if (px == X_LAST) begin
        x_d = 11'd0;
        if (py == Y_LAST) begin
          y_d     = 11'd0;
          state_d = WAIT_SOF;
        end else begin
          y_d = py + 11'd1;
        end
      end else begin
        x_d = px + 11'd1;
        y_d = py;
      end
    end
  end

  // Skid buffer: head drives the output, tail only fills while the head is stalled.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (cnt_q)
      2'd0: if (push) begin
        head_d = in_beat;
        cnt_d  = 2'd1;
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          tail_d = in_beat;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: if (pop) begin
        head_d = tail_q;
        cnt_d  = 2'd1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= WAIT_SOF;
      x_q       <= '0;
      y_q       <= '0;
      err_sof_q <= 1'b0;
      err_eol_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= 2'd0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      err_sof_q <= err_sof_d;
      err_eol_q <= err_eol_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      tready_q  <= (cnt_d != 2'd2);
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tuser  = head_q.user;
  assign m_axis_tlast  = head_q.last;
  assign locked        = (state_q == ACTIVE);
  assign err_sof       = err_sof_q;
  assign err_eol       = err_eol_q;

`ifdef FRAME_REGEN_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;
  logic        frame_done;

  // A restarted frame counts only when it actually reaches its last pixel.
  assign frame_done = push && (px == X_LAST) && (py == Y_LAST);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (frame_done)                                          frame_cnt_q <= frame_cnt_q + 16'd1;
      if (acc && state_q == WAIT_SOF && !s_axis_tuser)         drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule
